reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard.sv | 93 +++++++++
 tb/tb_reg_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write counters, RAW/saturation/PC-shadow stalls.
// Optional sticky protocol-error flag is built only when SB_ERR_EN is defined.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [3:0]  iss_rn,
  input  logic [3:0]  iss_rm,
  input  logic        iss_use_rn,
  input  logic        iss_use_rm,
  input  logic        iss_wr,
  input  logic [3:0]  iss_rd,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic        op_valid,
  output logic        pc_pending,
  output logic [15:0] busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [15:0][CNT_W-1:0] count_reg;
  logic [15:0][CNT_W-1:0] count_next;
  logic                   op_valid_reg;
  logic                   raw;
  logic                   sat;
  logic                   pcs;
  logic                   accept;

  // A same-cycle writeback does not release a stall: the register file
  // would still return the old value on that edge.
  assign raw       = (iss_use_rn & busy[iss_rn]) | (iss_use_rm & busy[iss_rm]);
  assign sat       = iss_wr & (count_reg[iss_rd] == CNT_MAX);
  assign pcs       = busy[15];
  assign iss_ready = ~(raw | sat | pcs);
  assign accept    = iss_valid & iss_ready;

  assign ra1        = iss_rn;
  assign ra2        = iss_rm;
  assign op_valid   = op_valid_reg;
  assign pc_pending = busy[15];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_cnt
      logic inc;
      logic dec;
      assign inc = accept & iss_wr & (iss_rd == 4'(gi));
      assign dec = wb_valid & (wb_addr == 4'(gi));
      // Underflow (dec at zero) saturates at zero; inc+dec together cancel.
      assign count_next[gi] =
          (inc & ~dec)                               ? count_reg[gi] + CNT_W'(1) :
          (dec & ~inc & (count_reg[gi] != '0))       ? count_reg[gi] - CNT_W'(1) :
                                                       count_reg[gi];
      assign busy[gi] = (count_reg[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      op_valid_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      op_valid_reg <= accept;
    end
  end

`ifdef SB_ERR_EN
  logic err_reg;
  logic err_set;

  assign err_set = (wb_valid & (count_reg[wb_addr] == '0)) | (accept & pcs);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, corner-case sequences,
// and randomized traffic against a counting reference model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_rn;
  logic [3:0]  iss_rm;
  logic        iss_use_rn;
  logic        iss_use_rm;
  logic        iss_wr;
  logic [3:0]  iss_rd;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic        op_valid;
  logic        pc_pending;
  logic [15:0] busy;
  logic        err;

`ifdef SB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rn(iss_rn), .iss_rm(iss_rm),
    .iss_use_rn(iss_use_rn), .iss_use_rm(iss_use_rm),
    .iss_wr(iss_wr), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .ra1(ra1), .ra2(ra2),
    .op_valid(op_valid), .pc_pending(pc_pending),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: number of outstanding writes per register.
  int cnt_m [16];
  bit opv_m;
  bit err_m;

  typedef struct {
    logic        v;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic        urn;
    logic        urm;
    logic        wr;
    logic [3:0]  rd;
    logic        wbv;
    logic [3:0]  wba;
    logic        exp_ready;
    logic [15:0] exp_busy;
    logic        exp_opv;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                       input logic urn, input logic urm, input logic wr, input logic [3:0] rd,
                       input logic wbv, input logic [3:0] wba);
    iss_valid = v;  iss_rn = rn;  iss_rm = rm;
    iss_use_rn = urn;  iss_use_rm = urm;
    iss_wr = wr;  iss_rd = rd;
    wb_valid = wbv;  wb_addr = wba;
  endtask

  function automatic bit model_ready();
    bit raw = (iss_use_rn && cnt_m[iss_rn] > 0) || (iss_use_rm && cnt_m[iss_rm] > 0);
    bit sat = iss_wr && cnt_m[iss_rd] == 3;
    return !(raw || sat || cnt_m[15] > 0);
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    for (int r = 0; r < 16; r++) b[r] = (cnt_m[r] > 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 16; r++) cnt_m[r] = 0;
    opv_m = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    if (reset) begin
      model_clear();
    end else begin
      acc = iss_valid && model_ready();
      if (ERR_EN && wb_valid && cnt_m[wb_addr] == 0) err_m = 1'b1;
      if (ERR_EN && acc && cnt_m[15] > 0) err_m = 1'b1;
      if (acc && iss_wr) cnt_m[iss_rd]++;
      if (wb_valid && cnt_m[wb_addr] > 0) cnt_m[wb_addr]--;
      opv_m = acc;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "_ready"}, 32'(iss_ready), 32'(model_ready()));
    chk({tag, "_busy"}, 32'(busy), 32'(model_busy()));
    chk({tag, "_pcpend"}, 32'(pc_pending), 32'(cnt_m[15] > 0));
    chk({tag, "_opv"}, 32'(op_valid), 32'(opv_m));
    chk({tag, "_err"}, 32'(err), 32'(err_m));
    chk({tag, "_ra"}, {24'd0, ra1, ra2}, {24'd0, iss_rn, iss_rm});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_wb(input logic wbv, input logic [3:0] wba);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, wbv, wba);
  endtask

  initial begin
    int q[$];
    int r;

    // row: v rn rm urn urm wr rd wbv wba | ready busy opv
    tbl[0] = '{1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 16'h0002, 1'b1};
    tbl[2] = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 16'h0002, 1'b0};
    tbl[3] = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 4'd1, 1'b0, 16'h0002, 1'b0};
    tbl[4] = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 16'h0040, 1'b1};

    reset = 1'b1;
    idle_wb(1'b0, 4'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(iss_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pcpend", 32'(pc_pending), 32'd0);
    chk("rst_opv", 32'(op_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Directed table: ADD r1<-r2,r3 then a dependent reader held through writeback.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].rn, tbl[i].rm, tbl[i].urn, tbl[i].urm,
            tbl[i].wr, tbl[i].rd, tbl[i].wbv, tbl[i].wba);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(iss_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_opv", i), 32'(op_valid), 32'(tbl[i].exp_opv));
      chk($sformatf("tbl%0d_ra", i), {24'd0, ra1, ra2}, {24'd0, tbl[i].rn, tbl[i].rm});
      @(posedge clk);
      @(negedge clk);
    end

    reset = 1'b1;
    idle_wb(1'b0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Saturation on r4, with a writeback coinciding with the 4th attempt.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
      cycle("sat_fill");
    end
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4);
    #1 chk("sat_wb_stall", 32'(iss_ready), 32'd0);
    cycle("sat_wb");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
    #1 chk("sat_release", 32'(iss_ready), 32'd1);
    cycle("sat_acc");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
    #1 chk("sat_full_again", 32'(iss_ready), 32'd0);
    cycle("sat_full");
    for (int i = 0; i < 3; i++) begin
      idle_wb(1'b1, 4'd4);
      cycle("sat_drain");
    end

    // Simultaneous accept and writeback on r5.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
    cycle("r5_a");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5);
    cycle("r5_both");
    idle_wb(1'b0, 4'd0);
    #1 chk("r5_still_busy", 32'(busy[5]), 32'd1);
    cycle("r5_hold");
    idle_wb(1'b1, 4'd5);
    cycle("r5_wb");
    idle_wb(1'b0, 4'd0);
    #1 chk("r5_clear", 32'(busy[5]), 32'd0);
    cycle("r5_done");

    // Branch shadow on r15.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0);
    cycle("pc_issue");
    drive(1'b1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0);
    #1 chk("pc_pending_set", 32'(pc_pending), 32'd1);
    chk("pc_shadow_stall", 32'(iss_ready), 32'd0);
    cycle("pc_wait");
    cycle("pc_wait");
    drive(1'b1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 4'd15);
    #1 chk("pc_wb_stall", 32'(iss_ready), 32'd0);
    cycle("pc_wb");
    drive(1'b1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0);
    #1 chk("pc_released", 32'(iss_ready), 32'd1);
    chk("pc_pending_clr", 32'(pc_pending), 32'd0);
    cycle("pc_next");
    idle_wb(1'b1, 4'd2);
    cycle("pc_drain");

    // Underflow writeback to r7: err only in the error-checking build.
    idle_wb(1'b1, 4'd7);
    cycle("uf_wb");
    idle_wb(1'b0, 4'd0);
    #1 chk("uf_err", 32'(err), 32'(ERR_EN));
    chk("uf_busy7", 32'(busy[7]), 32'd0);
    cycle("uf_hold");
    cycle("uf_hold");
    #1 chk("uf_err_sticky", 32'(err), 32'(ERR_EN));

    // Reset mid-operation discards pending writes and the sticky error.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0);
    cycle("mid_w3");
    reset = 1'b1;
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 4'd3);
    cycle("mid_rst");
    reset = 1'b0;
    idle_wb(1'b0, 4'd0);
    #1 chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_err0", 32'(err), 32'd0);
    chk("mid_opv0", 32'(op_valid), 32'd0);
    cycle("mid_idle");
    idle_wb(1'b1, 4'd3);
    cycle("mid_late_wb");
    idle_wb(1'b0, 4'd0);
    cycle("mid_after");

    reset = 1'b1;
    idle_wb(1'b0, 4'd0);
    cycle("rnd_rst");
    reset = 1'b0;

    // Randomized traffic; writebacks mostly target outstanding registers.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
            1'b0, 4'd0);
      q.delete();
      for (int k = 0; k < 16; k++) if (cnt_m[k] > 0) q.push_back(k);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        r = q[$urandom_range(0, q.size() - 1)];
        wb_valid = 1'b1;
        wb_addr  = 4'(r);
      end else if ($urandom_range(0, 40) == 0) begin
        wb_valid = 1'b1;
        wb_addr  = 4'($urandom_range(0, 15));
      end
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
